// File: rtl/pwm_pkg.sv
// Shared widths and count types for the PWM timebase and channel bank.
package pwm_pkg;

  localparam int PWM_WIDTH = 16;
  localparam int PSC_WIDTH = 8;

  typedef logic [PWM_WIDTH-1:0] pwm_count_t;
  typedef logic [PSC_WIDTH-1:0] psc_count_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider for the PWM timebase: emits one tick every active_psc+1 enabled clocks.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int psc_width = PSC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [psc_width-1:0] active_psc,
  output logic                 tick
);

  localparam logic [psc_width-1:0] PSC_ONE = 1;

  logic [psc_width-1:0] psc_cnt_q;
  logic [psc_width-1:0] psc_cnt_d;

  always_comb begin
    tick = enable && (psc_cnt_q == active_psc);
  end

  // Clearing on commit restarts the divider in phase with the new period.
  always_comb begin
    psc_cnt_d = psc_cnt_q + PSC_ONE;
    if (!enable || clear || tick) begin
      psc_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_cnt_q <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_timebase.sv
// Free-running PWM timebase with shadowed period/prescale and a commit handshake
// that swaps period and channel thresholds together on one overflow.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int                   pwm_width = PWM_WIDTH,
  parameter int                   psc_width = PSC_WIDTH,
  parameter logic [pwm_width-1:0] reset_top = {pwm_width{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [pwm_width-1:0] period_in,
  input  logic [psc_width-1:0] prescale_in,
  input  logic                 shadow_wr,
  input  logic                 update_req,
  output logic [pwm_width-1:0] counter,
  output logic                 overflow,
  output logic                 set_thres,
  output logic                 update_pending,
  output logic                 update_done
);

  localparam logic [pwm_width-1:0] CNT_ONE = 1;

  logic [pwm_width-1:0] counter_q, counter_d;
  logic [pwm_width-1:0] active_top_q, active_top_d;
  logic [psc_width-1:0] active_psc_q, active_psc_d;
  logic [pwm_width-1:0] shadow_top_q, shadow_top_d;
  logic [psc_width-1:0] shadow_psc_q, shadow_psc_d;
  logic                 pending_q, pending_d;
  logic                 done_q;
  logic                 tick;
  logic                 commit;

  pwm_prescaler #(
    .psc_width (psc_width)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clear      (commit),
    .active_psc (active_psc_q),
    .tick       (tick)
  );

  always_comb begin
    overflow = tick && (counter_q == active_top_q);
    commit   = overflow && pending_q;
  end

  // Commit reads the shadow registers before any same-cycle shadow write lands.
  always_comb begin
    shadow_top_d = shadow_top_q;
    shadow_psc_d = shadow_psc_q;
    active_top_d = active_top_q;
    active_psc_d = active_psc_q;
    pending_d    = pending_q;
    counter_d    = counter_q;
    if (shadow_wr) begin
      shadow_top_d = period_in;
      shadow_psc_d = prescale_in;
    end
    if (commit) begin
      active_top_d = shadow_top_q;
      active_psc_d = shadow_psc_q;
      pending_d    = update_req;
      counter_d    = '0;
    end else begin
      if (update_req) begin
        pending_d = 1'b1;
      end
      if (!enable) begin
        counter_d = '0;
      end else if (tick) begin
        counter_d = (counter_q == active_top_q) ? '0 : counter_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q    <= '0;
      active_top_q <= reset_top;
      active_psc_q <= '0;
      shadow_top_q <= reset_top;
      shadow_psc_q <= '0;
      pending_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      counter_q    <= counter_d;
      active_top_q <= active_top_d;
      active_psc_q <= active_psc_d;
      shadow_top_q <= shadow_top_d;
      shadow_psc_q <= shadow_psc_d;
      pending_q    <= pending_d;
      done_q       <= commit;
    end
  end

  // Channels see a zero count the moment the timebase is disabled.
  always_comb begin
    counter        = enable ? counter_q : '0;
    set_thres      = commit;
    update_pending = pending_q;
    update_done    = done_q;
  end

endmodule

// File: tb/tb_pwm_timebase.sv
// Self-checking bench for pwm_timebase: fixed vector table, directed corner sequences
// and random traffic, all compared against a period-position reference model.
module tb_pwm_timebase;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] period_in = '0;
  logic [7:0]  prescale_in = '0;
  logic        shadow_wr = 1'b0;
  logic        update_req = 1'b0;
  logic [15:0] counter;
  logic        overflow;
  logic        set_thres;
  logic        update_pending;
  logic        update_done;

  always #5 clk = ~clk;

  pwm_timebase #(
    .pwm_width (16),
    .psc_width (8),
    .reset_top (16'd3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .period_in      (period_in),
    .prescale_in    (prescale_in),
    .shadow_wr      (shadow_wr),
    .update_req     (update_req),
    .counter        (counter),
    .overflow       (overflow),
    .set_thres      (set_thres),
    .update_pending (update_pending),
    .update_done    (update_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Reference model: position inside the current period, in clocks.
  int m_top, m_psc, s_top, s_psc, m_pos;
  bit m_pend, m_done;

  int last_cnt;
  bit last_ovf, last_set, last_pend, last_done;

  logic [31:0] exp_q[$];

  function automatic int m_period();
    return (m_top + 1) * (m_psc + 1);
  endfunction

  function automatic bit m_ovf(bit en);
    return en && (m_pos == m_period() - 1);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_top = 3; m_psc = 0; s_top = 3; s_psc = 0;
    m_pos = 0; m_pend = 1'b0; m_done = 1'b0;
  endtask

  task automatic cycle(bit r, bit en, bit sw, bit ur, int per, int psc);
    int exp_cnt;
    bit exp_ovf, exp_set;
    @(negedge clk);
    rst = r; enable = en; shadow_wr = sw; update_req = ur;
    period_in = per[15:0]; prescale_in = psc[7:0];
    #1;
    exp_cnt = en ? m_pos / (m_psc + 1) : 0;
    exp_ovf = m_ovf(en);
    exp_set = exp_ovf && m_pend;
    last_cnt = int'(counter); last_ovf = overflow; last_set = set_thres;
    last_pend = update_pending; last_done = update_done;
    if (chk_en) begin
      check("counter", int'(counter), exp_cnt);
      check("overflow", int'(overflow), int'(exp_ovf));
      check("set_thres", int'(set_thres), int'(exp_set));
      check("update_pending", int'(update_pending), int'(m_pend));
      check("update_done", int'(update_done), int'(m_done));
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      m_done = exp_set;
      if (exp_set) begin
        m_top = s_top; m_psc = s_psc; m_pos = 0; m_pend = ur;
      end else begin
        m_pend = m_pend | ur;
        m_pos = (!en || exp_ovf) ? 0 : m_pos + 1;
      end
      if (sw) begin
        s_top = per; s_psc = psc;
      end
    end
    cyc++;
  endtask

  task automatic idle(int n, bit en);
    for (int i = 0; i < n; i++) cycle(1'b0, en, 1'b0, 1'b0, 0, 0);
  endtask

  // Idles until the model says the next enabled cycle is a commit cycle.
  task automatic wait_commit(int max_cycles);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      if (m_ovf(1'b1) && m_pend) found = 1'b1;
      else cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    end
    check("wait_commit_reached", int'(found), 1);
  endtask

  typedef struct {
    bit r, en, sw, ur;
    int per, psc;
    int cnt;
    bit ovf, set, pend, done;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int last_ov_cyc;
    int en_cycles;
    bit seen;

    model_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    chk_en = 1'b1;

    // Reset top is 3, prescale 0.
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 1, 0, 0, 2, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 0, 0, 0, 3, 1, 1, 1, 0};
    tbl[13] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[14] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[15] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[19] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[20] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0};

    for (int i = 0; i < 21; i++) begin
      cycle(tbl[i].r, tbl[i].en, tbl[i].sw, tbl[i].ur, tbl[i].per, tbl[i].psc);
      check($sformatf("tbl%0d_counter", i), last_cnt, tbl[i].cnt);
      check($sformatf("tbl%0d_overflow", i), int'(last_ovf), int'(tbl[i].ovf));
      check($sformatf("tbl%0d_set_thres", i), int'(last_set), int'(tbl[i].set));
      check($sformatf("tbl%0d_pending", i), int'(last_pend), int'(tbl[i].pend));
      check($sformatf("tbl%0d_done", i), int'(last_done), int'(tbl[i].done));
    end

    // top=4, psc=2: overflows one clock wide every 15 clocks.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4, 2);
    wait_commit(20);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    check("seqA_commit_set", int'(last_set), 1);
    last_ov_cyc = cyc - 1;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    check("seqA_done_after_commit", int'(last_done), 1);
    repeat (3) exp_q.push_back(32'd15);
    for (int i = 0; i < 48; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      if (last_ovf) begin
        if (exp_q.size() == 0) check("seqA_extra_overflow", 1, 0);
        else check("seqA_overflow_gap", cyc - 1 - last_ov_cyc, int'(exp_q.pop_front()));
        last_ov_cyc = cyc - 1;
      end
    end
    check("seqA_overflows_seen", exp_q.size(), 0);

    // top=9, then request top=4 mid-period at counter=5.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 9, 0);
    wait_commit(20);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 20 && !(m_pos == 4); i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 4, 0);
    check("seqB_counter_at_req", m_pos, 5);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
    wait_commit(20);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    check("seqB_commit_at_top", last_cnt, 9);
    check("seqB_commit_set", int'(last_set), 1);
    idle(12, 1'b1);

    // Request and shadow write landing in the commit cycle itself.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 6, 0);
    wait_commit(20);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 7, 0);
    check("seqC_commit_set", int'(last_set), 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    check("seqC_pending_kept", int'(last_pend), 1);
    wait_commit(20);
    check("seqC_old_shadow_top", m_top, 6);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    check("seqC_second_commit_at6", last_cnt, 6);
    check("seqC_second_commit_set", int'(last_set), 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      if (last_ovf) begin
        seen = 1'b1;
        check("seqC_new_top7", last_cnt, 7);
      end
    end
    check("seqC_overflow_seen", int'(seen), 1);

    // top=0: overflow every cycle, request commits on the very next cycle.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
    wait_commit(20);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    idle(5, 1'b1);
    check("seqD_overflow_each", int'(last_ovf), 1);
    check("seqD_counter_zero", last_cnt, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
    check("seqD_no_set_on_req", int'(last_set), 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    check("seqD_set_next", int'(last_set), 1);

    // Reset discards a pending request; disable mid-period; re-enable timing.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 5, 1);
    wait_commit(20);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
    idle(3, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    check("seqE_pending_cleared", int'(last_pend), 0);
    idle(2, 1'b1);
    idle(4, 1'b0);
    check("seqE_counter_disabled", last_cnt, 0);
    en_cycles = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      en_cycles++;
      check("seqE_no_set_thres", int'(last_set), 0);
      if (last_ovf) seen = 1'b1;
    end
    check("seqE_first_overflow_clocks", en_cycles, 4);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
